// File: rtl/calc_entry_ctrl_pkg.sv
// Shared key codes, state encoding and key-classification helpers for the
// calculator keypad-entry controller.
package calc_entry_ctrl_pkg;

   localparam logic [3:0] KEY_ADD   = 4'hA;
   localparam logic [3:0] KEY_SUB   = 4'hB;
   localparam logic [3:0] KEY_MUL   = 4'hC;
   localparam logic [3:0] KEY_DIV   = 4'hD;
   localparam logic [3:0] KEY_EQ    = 4'hE;
   localparam logic [3:0] KEY_CLR   = 4'hF;
   localparam logic [3:0] PEND_NONE = 4'h0;

   typedef enum logic [2:0] {
      ST_ENTER_A = 3'd0,
      ST_OP_WAIT = 3'd1,
      ST_ENTER_B = 3'd2,
      ST_CALC    = 3'd3,
      ST_SHOW    = 3'd4,
      ST_ERROR   = 3'd5
   } state_e;

   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

   function automatic logic is_op(input logic [3:0] k);
      return (k >= KEY_ADD) && (k <= KEY_DIV);
   endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// Key-scanner / ALU / display signal bundle for the keypad-entry controller.
interface calc_entry_ctrl_if #(parameter int DIGITS = 6);

   localparam int DW = 4 * DIGITS;

   logic          key_valid;
   logic [3:0]    key_value;
   logic [DW-1:0] alu_result;
   logic          alu_done;
   logic          alu_err;
   logic          alu_start;
   logic [DW-1:0] operand_a;
   logic [DW-1:0] operand_b;
   logic [3:0]    opcode;
   logic          busy;
   logic          error;
   logic [DW-1:0] num_out;

   modport master (
      output key_valid, key_value, alu_result, alu_done, alu_err,
      input  alu_start, operand_a, operand_b, opcode, busy, error, num_out
   );

   modport slave (
      input  key_valid, key_value, alu_result, alu_done, alu_err,
      output alu_start, operand_a, operand_b, opcode, busy, error, num_out
   );

endinterface

// File: rtl/calc_entry_ctrl_digit_reg.sv
// BCD operand register: shifts digits in from the right, tracks the digit count,
// and can be loaded whole (optionally locked full so no digits can be appended).
module calc_entry_ctrl_digit_reg #(
   parameter int DIGITS = 6
) (
   input  logic                  CLK_1K,
   input  logic                  RSTN,
   input  logic                  shift_en,
   input  logic                  load_en,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  clr,
   input  logic                  lock,
   output logic [4*DIGITS-1:0]   value,
   output logic                  full
);

   localparam int DW = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

   logic [DW-1:0] value_r;
   logic [CW-1:0] count_r;

   // Operand and digit count; the shifted digit is load_val's low nibble, leading zeros are not counted.
   always_ff @(posedge CLK_1K or negedge RSTN) begin
      if (!RSTN) begin
         value_r <= '0;
         count_r <= '0;
      end else if (clr) begin
         value_r <= '0;
         count_r <= '0;
      end else if (load_en) begin
         value_r <= load_val;
         count_r <= lock ? CNT_MAX : CW'(1);
      end else if (shift_en && (count_r != CNT_MAX)) begin
         value_r <= {value_r[DW-5:0], load_val[3:0]};
         if ((count_r != '0) || (load_val[3:0] != 4'h0)) begin
            count_r <= count_r + CW'(1);
         end
      end
   end

   assign value = value_r;
   assign full  = (count_r == CNT_MAX);

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad-entry controller: assembles two BCD operands from key codes, launches the
// ALU with a start/done handshake and chains each result into the next operation.
module calc_entry_ctrl
   import calc_entry_ctrl_pkg::*;
#(
   parameter int         DIGITS  = 6,
   parameter logic [3:0] CLR_KEY = KEY_CLR
) (
   input  logic             CLK_1K,
   input  logic             RSTN,
   calc_entry_ctrl_if.slave bus
);

   localparam int DW = 4 * DIGITS;

   state_e        state_r;
   logic [3:0]    opcode_r;
   logic [3:0]    pending_r;
   logic          alu_start_r;
   logic          busy_r;
   logic          error_r;

   logic          key_clr_s, key_digit_s, key_op_s, key_eq_s;
   logic [DW-1:0] digit_ext_s;
   logic          a_shift_s, a_load_s, a_lock_s, a_clr_s, a_full_s;
   logic          b_shift_s, b_load_s, b_clr_s, b_full_s;
   logic [DW-1:0] a_load_val_s, a_value_s, b_value_s, num_s;

   // Key classification; CLR wins over any other interpretation of the code.
   always_comb begin
      key_clr_s   = bus.key_valid && (bus.key_value == CLR_KEY);
      key_digit_s = bus.key_valid && !key_clr_s && is_digit(bus.key_value);
      key_op_s    = bus.key_valid && !key_clr_s && is_op(bus.key_value);
      key_eq_s    = bus.key_valid && !key_clr_s && (bus.key_value == KEY_EQ);
      digit_ext_s = {{(DW-4){1'b0}}, bus.key_value};
   end

   // Operand register controls; in CALC a clean alu_done locks the result into A.
   always_comb begin
      a_shift_s    = 1'b0;
      a_load_s     = 1'b0;
      a_lock_s     = 1'b0;
      a_clr_s      = 1'b0;
      b_shift_s    = 1'b0;
      b_load_s     = 1'b0;
      b_clr_s      = 1'b0;
      a_load_val_s = digit_ext_s;
      if (key_clr_s) begin
         a_clr_s = 1'b1;
         b_clr_s = 1'b1;
      end else begin
         case (state_r)
            ST_ENTER_A: a_shift_s = key_digit_s && !a_full_s;
            ST_OP_WAIT: b_load_s  = key_digit_s;
            ST_ENTER_B: b_shift_s = key_digit_s && !b_full_s;
            ST_CALC: begin
               a_load_s     = bus.alu_done && !bus.alu_err;
               a_lock_s     = 1'b1;
               a_load_val_s = bus.alu_result;
               b_clr_s      = bus.alu_done && !bus.alu_err;
            end
            ST_SHOW:    a_load_s  = key_digit_s;
            default:    a_shift_s = 1'b0;
         endcase
      end
   end

   calc_entry_ctrl_digit_reg #(.DIGITS(DIGITS)) u_reg_a (
      .CLK_1K   (CLK_1K),
      .RSTN     (RSTN),
      .shift_en (a_shift_s),
      .load_en  (a_load_s),
      .load_val (a_load_val_s),
      .clr      (a_clr_s),
      .lock     (a_lock_s),
      .value    (a_value_s),
      .full     (a_full_s)
   );

   calc_entry_ctrl_digit_reg #(.DIGITS(DIGITS)) u_reg_b (
      .CLK_1K   (CLK_1K),
      .RSTN     (RSTN),
      .shift_en (b_shift_s),
      .load_en  (b_load_s),
      .load_val (digit_ext_s),
      .clr      (b_clr_s),
      .lock     (1'b0),
      .value    (b_value_s),
      .full     (b_full_s)
   );

   // Control FSM with registered opcode, pending operator and handshake flags.
   always_ff @(posedge CLK_1K or negedge RSTN) begin
      if (!RSTN) begin
         state_r     <= ST_ENTER_A;
         opcode_r    <= 4'h0;
         pending_r   <= PEND_NONE;
         alu_start_r <= 1'b0;
         busy_r      <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         alu_start_r <= 1'b0;
         if (key_clr_s) begin
            state_r   <= ST_ENTER_A;
            opcode_r  <= 4'h0;
            pending_r <= PEND_NONE;
            busy_r    <= 1'b0;
            error_r   <= 1'b0;
         end else begin
            case (state_r)
               ST_ENTER_A: begin
                  if (key_op_s) begin
                     opcode_r <= bus.key_value;
                     state_r  <= ST_OP_WAIT;
                  end
               end
               ST_OP_WAIT: begin
                  if (key_op_s) begin
                     opcode_r <= bus.key_value;
                  end else if (key_digit_s) begin
                     state_r <= ST_ENTER_B;
                  end
               end
               ST_ENTER_B: begin
                  if (key_eq_s || key_op_s) begin
                     pending_r   <= key_eq_s ? PEND_NONE : bus.key_value;
                     state_r     <= ST_CALC;
                     busy_r      <= 1'b1;
                     alu_start_r <= 1'b1;
                  end
               end
               ST_CALC: begin
                  if (bus.alu_done) begin
                     busy_r <= 1'b0;
                     if (bus.alu_err) begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                     end else if (pending_r == PEND_NONE) begin
                        state_r <= ST_SHOW;
                     end else begin
                        opcode_r  <= pending_r;
                        pending_r <= PEND_NONE;
                        state_r   <= ST_OP_WAIT;
                     end
                  end
               end
               ST_SHOW: begin
                  if (key_digit_s) begin
                     opcode_r <= 4'h0;
                     state_r  <= ST_ENTER_A;
                  end else if (key_op_s) begin
                     opcode_r <= bus.key_value;
                     state_r  <= ST_OP_WAIT;
                  end
               end
               ST_ERROR: state_r <= ST_ERROR;
               default: begin
                  state_r <= ST_ENTER_A;
                  busy_r  <= 1'b0;
                  error_r <= 1'b0;
               end
            endcase
         end
      end
   end

   // Display source select.
   always_comb begin
      case (state_r)
         ST_ENTER_B: num_s = b_value_s;
         ST_ERROR:   num_s = {DIGITS{4'hE}};
         default:    num_s = a_value_s;
      endcase
   end

   assign bus.alu_start = alu_start_r;
   assign bus.operand_a = a_value_s;
   assign bus.operand_b = b_value_s;
   assign bus.opcode    = opcode_r;
   assign bus.busy      = busy_r;
   assign bus.error     = error_r;
   assign bus.num_out   = num_s;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed, table-driven bench for calc_entry_ctrl with hand-computed expectations.
module tb_calc_entry_ctrl;

   logic CLK_1K = 1'b0;
   logic RSTN   = 1'b0;

   calc_entry_ctrl_if #(.DIGITS(6)) bus ();

   calc_entry_ctrl #(.DIGITS(6), .CLR_KEY(4'hF)) dut (
      .CLK_1K (CLK_1K),
      .RSTN   (RSTN),
      .bus    (bus)
   );

   always #5 CLK_1K = ~CLK_1K;

   typedef struct {
      logic        kv;
      logic [3:0]  key;
      logic        done;
      logic        err;
      logic [23:0] res;
      logic [23:0] ea;
      logic [23:0] eb;
      logic [3:0]  eop;
      logic        est;
      logic        ebusy;
      logic        eerr;
      logic [23:0] enum_v;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic kv, input logic [3:0] key, input logic done,
                               input logic err, input logic [23:0] res, input logic [23:0] ea,
                               input logic [23:0] eb, input logic [3:0] eop, input logic est,
                               input logic ebusy, input logic eerr, input logic [23:0] enum_v);
      vec_t v;
      v.kv = kv; v.key = key; v.done = done; v.err = err; v.res = res;
      v.ea = ea; v.eb = eb; v.eop = eop; v.est = est; v.ebusy = ebusy;
      v.eerr = eerr; v.enum_v = enum_v;
      return v;
   endfunction

   task automatic drive(input logic kv, input logic [3:0] key, input logic done,
                        input logic err, input logic [23:0] res);
      @(negedge CLK_1K);
      bus.key_valid  = kv;
      bus.key_value  = key;
      bus.alu_done   = done;
      bus.alu_err    = err;
      bus.alu_result = res;
      @(posedge CLK_1K);
      #1;
   endtask

   task automatic check(input string tag, input logic [23:0] ea, input logic [23:0] eb,
                        input logic [3:0] eop, input logic est, input logic ebusy,
                        input logic eerr, input logic [23:0] enum_v);
      n_vec++;
      if (bus.operand_a !== ea) begin
         n_bad++; $display("FAIL %s operand_a got %h want %h", tag, bus.operand_a, ea);
      end
      if (bus.operand_b !== eb) begin
         n_bad++; $display("FAIL %s operand_b got %h want %h", tag, bus.operand_b, eb);
      end
      if (bus.opcode !== eop) begin
         n_bad++; $display("FAIL %s opcode got %h want %h", tag, bus.opcode, eop);
      end
      if (bus.alu_start !== est) begin
         n_bad++; $display("FAIL %s alu_start got %b want %b", tag, bus.alu_start, est);
      end
      if (bus.busy !== ebusy) begin
         n_bad++; $display("FAIL %s busy got %b want %b", tag, bus.busy, ebusy);
      end
      if (bus.error !== eerr) begin
         n_bad++; $display("FAIL %s error got %b want %b", tag, bus.error, eerr);
      end
      if (bus.num_out !== enum_v) begin
         n_bad++; $display("FAIL %s num_out got %h want %h", tag, bus.num_out, enum_v);
      end
   endtask

   initial begin
      // 1,2,A,3,E then ALU returns 15
      vecs.push_back(mk(1, 4'h1, 0, 0, 24'h0,      24'h1,      24'h0, 4'h0, 0, 0, 0, 24'h1));
      vecs.push_back(mk(1, 4'h2, 0, 0, 24'h0,      24'h12,     24'h0, 4'h0, 0, 0, 0, 24'h12));
      vecs.push_back(mk(1, 4'hA, 0, 0, 24'h0,      24'h12,     24'h0, 4'hA, 0, 0, 0, 24'h12));
      vecs.push_back(mk(1, 4'h3, 0, 0, 24'h0,      24'h12,     24'h3, 4'hA, 0, 0, 0, 24'h3));
      vecs.push_back(mk(1, 4'hE, 0, 0, 24'h0,      24'h12,     24'h3, 4'hA, 1, 1, 0, 24'h12));
      vecs.push_back(mk(0, 4'h0, 0, 0, 24'h0,      24'h12,     24'h3, 4'hA, 0, 1, 0, 24'h12));
      vecs.push_back(mk(0, 4'h0, 1, 0, 24'h15,     24'h15,     24'h0, 4'hA, 0, 0, 0, 24'h15));
      // seven digits from SHOW; the seventh is dropped
      vecs.push_back(mk(1, 4'h1, 0, 0, 24'h0,      24'h1,      24'h0, 4'h0, 0, 0, 0, 24'h1));
      vecs.push_back(mk(1, 4'h2, 0, 0, 24'h0,      24'h12,     24'h0, 4'h0, 0, 0, 0, 24'h12));
      vecs.push_back(mk(1, 4'h3, 0, 0, 24'h0,      24'h123,    24'h0, 4'h0, 0, 0, 0, 24'h123));
      vecs.push_back(mk(1, 4'h4, 0, 0, 24'h0,      24'h1234,   24'h0, 4'h0, 0, 0, 0, 24'h1234));
      vecs.push_back(mk(1, 4'h5, 0, 0, 24'h0,      24'h12345,  24'h0, 4'h0, 0, 0, 0, 24'h12345));
      vecs.push_back(mk(1, 4'h6, 0, 0, 24'h0,      24'h123456, 24'h0, 4'h0, 0, 0, 0, 24'h123456));
      vecs.push_back(mk(1, 4'h7, 0, 0, 24'h0,      24'h123456, 24'h0, 4'h0, 0, 0, 0, 24'h123456));
      vecs.push_back(mk(1, 4'hF, 0, 0, 24'h0,      24'h0,      24'h0, 4'h0, 0, 0, 0, 24'h0));
      // chaining 5 A 2 B -> 7, then 1 E; done with a simultaneous key drops the key
      vecs.push_back(mk(1, 4'h5, 0, 0, 24'h0,      24'h5,      24'h0, 4'h0, 0, 0, 0, 24'h5));
      vecs.push_back(mk(1, 4'hA, 0, 0, 24'h0,      24'h5,      24'h0, 4'hA, 0, 0, 0, 24'h5));
      vecs.push_back(mk(1, 4'h2, 0, 0, 24'h0,      24'h5,      24'h2, 4'hA, 0, 0, 0, 24'h2));
      vecs.push_back(mk(1, 4'hB, 0, 0, 24'h0,      24'h5,      24'h2, 4'hA, 1, 1, 0, 24'h5));
      vecs.push_back(mk(0, 4'h0, 1, 0, 24'h7,      24'h7,      24'h0, 4'hB, 0, 0, 0, 24'h7));
      vecs.push_back(mk(1, 4'h1, 0, 0, 24'h0,      24'h7,      24'h1, 4'hB, 0, 0, 0, 24'h1));
      vecs.push_back(mk(1, 4'hE, 0, 0, 24'h0,      24'h7,      24'h1, 4'hB, 1, 1, 0, 24'h7));
      vecs.push_back(mk(1, 4'h3, 1, 0, 24'h6,      24'h6,      24'h0, 4'hB, 0, 0, 0, 24'h6));
      vecs.push_back(mk(1, 4'hE, 0, 0, 24'h0,      24'h6,      24'h0, 4'hB, 0, 0, 0, 24'h6));
      // 9 D 0 E with error; keys and stray done ignored; F recovers
      vecs.push_back(mk(1, 4'h9, 0, 0, 24'h0,      24'h9,      24'h0, 4'h0, 0, 0, 0, 24'h9));
      vecs.push_back(mk(1, 4'hD, 0, 0, 24'h0,      24'h9,      24'h0, 4'hD, 0, 0, 0, 24'h9));
      vecs.push_back(mk(1, 4'h0, 0, 0, 24'h0,      24'h9,      24'h0, 4'hD, 0, 0, 0, 24'h0));
      vecs.push_back(mk(1, 4'hE, 0, 0, 24'h0,      24'h9,      24'h0, 4'hD, 1, 1, 0, 24'h9));
      vecs.push_back(mk(0, 4'h0, 1, 1, 24'h999999, 24'h9,      24'h0, 4'hD, 0, 0, 1, 24'hEEEEEE));
      vecs.push_back(mk(1, 4'h5, 0, 0, 24'h0,      24'h9,      24'h0, 4'hD, 0, 0, 1, 24'hEEEEEE));
      vecs.push_back(mk(1, 4'hA, 0, 0, 24'h0,      24'h9,      24'h0, 4'hD, 0, 0, 1, 24'hEEEEEE));
      vecs.push_back(mk(0, 4'h0, 1, 0, 24'h111,    24'h9,      24'h0, 4'hD, 0, 0, 1, 24'hEEEEEE));
      vecs.push_back(mk(1, 4'hF, 0, 0, 24'h0,      24'h0,      24'h0, 4'h0, 0, 0, 0, 24'h0));
      // F during CALC, late alu_done discarded, digit then lands in A
      vecs.push_back(mk(1, 4'h1, 0, 0, 24'h0,      24'h1,      24'h0, 4'h0, 0, 0, 0, 24'h1));
      vecs.push_back(mk(1, 4'hA, 0, 0, 24'h0,      24'h1,      24'h0, 4'hA, 0, 0, 0, 24'h1));
      vecs.push_back(mk(1, 4'h2, 0, 0, 24'h0,      24'h1,      24'h2, 4'hA, 0, 0, 0, 24'h2));
      vecs.push_back(mk(1, 4'hE, 0, 0, 24'h0,      24'h1,      24'h2, 4'hA, 1, 1, 0, 24'h1));
      vecs.push_back(mk(1, 4'hF, 0, 0, 24'h0,      24'h0,      24'h0, 4'h0, 0, 0, 0, 24'h0));
      vecs.push_back(mk(0, 4'h0, 0, 0, 24'h0,      24'h0,      24'h0, 4'h0, 0, 0, 0, 24'h0));
      vecs.push_back(mk(0, 4'h0, 1, 0, 24'h3,      24'h0,      24'h0, 4'h0, 0, 0, 0, 24'h0));
      vecs.push_back(mk(1, 4'h4, 0, 0, 24'h0,      24'h4,      24'h0, 4'h0, 0, 0, 0, 24'h4));

      bus.key_valid  = 1'b0;
      bus.key_value  = 4'h0;
      bus.alu_done   = 1'b0;
      bus.alu_err    = 1'b0;
      bus.alu_result = 24'h0;

      repeat (2) @(negedge CLK_1K);
      check("reset", 24'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0, 24'h0);
      RSTN = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].kv, vecs[i].key, vecs[i].done, vecs[i].err, vecs[i].res);
         check($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].eop, vecs[i].est,
               vecs[i].ebusy, vecs[i].eerr, vecs[i].enum_v);
      end

      // Asynchronous reset while in ENTER_B, asserted between clock edges
      drive(1'b1, 4'hF, 1'b0, 1'b0, 24'h0);
      drive(1'b1, 4'h1, 1'b0, 1'b0, 24'h0);
      drive(1'b1, 4'hA, 1'b0, 1'b0, 24'h0);
      drive(1'b1, 4'h2, 1'b0, 1'b0, 24'h0);
      check("pre_rst", 24'h1, 24'h2, 4'hA, 1'b0, 1'b0, 1'b0, 24'h2);
      #2;
      RSTN = 1'b0;
      #1;
      check("async_rst", 24'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0, 24'h0);
      @(negedge CLK_1K);
      bus.key_valid = 1'b0;
      bus.key_value = 4'h0;
      @(negedge CLK_1K);
      RSTN = 1'b1;
      drive(1'b1, 4'hE, 1'b0, 1'b0, 24'h0);
      check("post_rst_eq", 24'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0, 24'h0);
      for (int j = 0; j < 4; j++) begin
         drive(1'b0, 4'h0, 1'b0, 1'b0, 24'h0);
         check($sformatf("post_rst_idle%0d", j), 24'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0, 24'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
